// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU op sequencer: funct codes, result-mux
// encodings, the sequencer state type and a small decode helper.
package alu_pkg;

  // MIPS R-type funct codes handled by the sequencer
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  // Result mux select encodings
  localparam logic [1:0] SEL_ALU = 2'd0;
  localparam logic [1:0] SEL_SHT = 2'd1;
  localparam logic [1:0] SEL_HI  = 2'd2;
  localparam logic [1:0] SEL_LO  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  // True for the codes whose funct value is passed straight to the ALU
  function automatic logic is_alu_op(input logic [5:0] f);
    return (f == F_AND) || (f == F_OR) || (f == F_ADD) ||
           (f == F_SUB) || (f == F_SLT);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/control bundle between instruction decode, the sequencer and the
// datapath. Optional divider controls exist only with DIVU_SUPPORT_EN.
interface alu_op_sequencer_if;

  logic       req_valid;
  logic       req_ready;
  logic [5:0] funct;
  logic [5:0] alu_signal;
  logic       shift_en;
  logic       mul_en;
  logic       mul_start;
  logic       hilo_we;
  logic [1:0] out_sel;
  logic       done;
  logic       err;
`ifdef DIVU_SUPPORT_EN
  logic       div_en;
  logic       div_start;

  modport master (
    output req_valid, funct,
    input  req_ready, alu_signal, shift_en, mul_en, mul_start, hilo_we,
           out_sel, done, err, div_en, div_start
  );
  modport slave (
    input  req_valid, funct,
    output req_ready, alu_signal, shift_en, mul_en, mul_start, hilo_we,
           out_sel, done, err, div_en, div_start
  );
`else
  modport master (
    output req_valid, funct,
    input  req_ready, alu_signal, shift_en, mul_en, mul_start, hilo_we,
           out_sel, done, err
  );
  modport slave (
    input  req_valid, funct,
    output req_ready, alu_signal, shift_en, mul_en, mul_start, hilo_we,
           out_sel, done, err
  );
`endif

endinterface

// File: rtl/alu_op_cycle_counter.sv
// Step counter for multi-cycle operations: clear has priority over enable,
// tc flags the last step (count == TERM).
module alu_op_cycle_counter #(
  parameter int CNT_W = 6,
  parameter int TERM  = 31
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear, step, or hold
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {CNT_W{1'b0}};
    end else if (en) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register, async active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == CNT_W'(TERM));

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU op sequencer: accepts one funct per handshake and drives registered
// datapath controls. MULTU (and DIVU when DIVU_SUPPORT_EN is defined) hold
// the unit enable for MUL_CYCLES cycles and then write HI/LO.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int MUL_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic               clk,
  input  logic               reset,
  alu_op_sequencer_if.slave  bus
);

  state_e     state_q, state_d;
  logic [5:0] funct_q, funct_d;
  logic       xfer, long_req, is_div, cnt_en, cnt_clr, cnt_tc;

  logic [5:0] alu_signal_q, alu_signal_d;
  logic [1:0] out_sel_q, out_sel_d;
  logic       shift_en_q, shift_en_d, mul_en_q, mul_en_d;
  logic       mul_start_q, mul_start_d, hilo_we_q, hilo_we_d;
  logic       done_q, done_d, err_q, err_d;
  logic       div_en_q, div_en_d, div_start_q, div_start_d;

  assign bus.req_ready = (state_q == ST_IDLE);
  assign xfer          = bus.req_valid && (state_q == ST_IDLE);
  assign funct_d       = xfer ? bus.funct : funct_q;

`ifdef DIVU_SUPPORT_EN
  assign long_req = (bus.funct == F_MULTU) || (bus.funct == F_DIVU);
  assign is_div   = (funct_d == F_DIVU);
`else
  assign long_req = (bus.funct == F_MULTU);
  assign is_div   = 1'b0;
`endif

  // Step counter runs only in MUL and rewinds on the last step
  assign cnt_en  = (state_q == ST_MUL);
  assign cnt_clr = !cnt_en || cnt_tc;

  alu_op_cycle_counter #(.CNT_W(CNT_W), .TERM(MUL_CYCLES - 1)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  // State, latched funct and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      funct_q      <= 6'b000000;
      alu_signal_q <= 6'b000000;
      out_sel_q    <= SEL_ALU;
      shift_en_q   <= 1'b0;
      mul_en_q     <= 1'b0;
      mul_start_q  <= 1'b0;
      hilo_we_q    <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      div_en_q     <= 1'b0;
      div_start_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      funct_q      <= funct_d;
      alu_signal_q <= alu_signal_d;
      out_sel_q    <= out_sel_d;
      shift_en_q   <= shift_en_d;
      mul_en_q     <= mul_en_d;
      mul_start_q  <= mul_start_d;
      hilo_we_q    <= hilo_we_d;
      done_q       <= done_d;
      err_q        <= err_d;
      div_en_q     <= div_en_d;
      div_start_q  <= div_start_d;
    end
  end

  // Next-state: EXEC and WB last one cycle, MUL runs until terminal count
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          state_d = long_req ? ST_MUL : ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: state_d = ST_IDLE;
      ST_MUL: begin
        if (cnt_tc) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_MUL;
        end
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every control is a flop
  always_comb begin
    alu_signal_d = 6'b000000;
    out_sel_d    = SEL_ALU;
    shift_en_d   = 1'b0;
    mul_en_d     = 1'b0;
    mul_start_d  = 1'b0;
    hilo_we_d    = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    div_en_d     = 1'b0;
    div_start_d  = 1'b0;
    case (state_d)
      ST_EXEC: begin
        done_d = 1'b1;
        if (is_alu_op(funct_d)) begin
          alu_signal_d = funct_d;
        end else if (funct_d == F_SRL) begin
          shift_en_d = 1'b1;
          out_sel_d  = SEL_SHT;
        end else if (funct_d == F_MFHI) begin
          out_sel_d = SEL_HI;
        end else if (funct_d == F_MFLO) begin
          out_sel_d = SEL_LO;
        end else begin
          err_d = 1'b1;
        end
      end
      ST_MUL: begin
        if (is_div) begin
          div_en_d    = 1'b1;
          div_start_d = (state_q == ST_IDLE);
        end else begin
          mul_en_d    = 1'b1;
          mul_start_d = (state_q == ST_IDLE);
        end
      end
      ST_WB: begin
        hilo_we_d = 1'b1;
        done_d    = 1'b1;
        out_sel_d = SEL_HI;
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  assign bus.alu_signal = alu_signal_q;
  assign bus.out_sel    = out_sel_q;
  assign bus.shift_en   = shift_en_q;
  assign bus.mul_en     = mul_en_q;
  assign bus.mul_start  = mul_start_q;
  assign bus.hilo_we    = hilo_we_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
`ifdef DIVU_SUPPORT_EN
  assign bus.div_en     = div_en_q;
  assign bus.div_start  = div_start_q;
`else
  logic unused_div;
  assign unused_div = div_en_q ^ div_start_q;
`endif

endmodule
